// File: rtl/regfile_write_bank_pkg.sv
// Shared constants for the register-file write bank and its address decoder.
// Defines the default widths, the register count and the register-zero address.
package regfile_write_bank_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG       = 2 ** ADDR_W_DEF;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dec5to32.sv
// 5-to-32 one-hot decoder with enable; the write-side mirror of the read mux tree.
// All outputs are low when the enable is low.
module dec5to32
    import regfile_write_bank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     en,
    output logic [(2**ADDR_W)-1:0]   onehot
);

    // one-hot decode of addr, gated by en
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32x32 register file: one-entry write-back stage plus storage.
// Register 0 has no storage; writes to it are staged and then dropped at commit.
module regfile_write_bank
    import regfile_write_bank_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              freeze,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [WIDTH-1:0]  pend_data,
    output logic [WIDTH-1:0]  reg_q0,
    output logic [WIDTH-1:0]  reg_q1,
    output logic [WIDTH-1:0]  reg_q2,
    output logic [WIDTH-1:0]  reg_q3,
    output logic [WIDTH-1:0]  reg_q4,
    output logic [WIDTH-1:0]  reg_q5,
    output logic [WIDTH-1:0]  reg_q6,
    output logic [WIDTH-1:0]  reg_q7,
    output logic [WIDTH-1:0]  reg_q8,
    output logic [WIDTH-1:0]  reg_q9,
    output logic [WIDTH-1:0]  reg_q10,
    output logic [WIDTH-1:0]  reg_q11,
    output logic [WIDTH-1:0]  reg_q12,
    output logic [WIDTH-1:0]  reg_q13,
    output logic [WIDTH-1:0]  reg_q14,
    output logic [WIDTH-1:0]  reg_q15,
    output logic [WIDTH-1:0]  reg_q16,
    output logic [WIDTH-1:0]  reg_q17,
    output logic [WIDTH-1:0]  reg_q18,
    output logic [WIDTH-1:0]  reg_q19,
    output logic [WIDTH-1:0]  reg_q20,
    output logic [WIDTH-1:0]  reg_q21,
    output logic [WIDTH-1:0]  reg_q22,
    output logic [WIDTH-1:0]  reg_q23,
    output logic [WIDTH-1:0]  reg_q24,
    output logic [WIDTH-1:0]  reg_q25,
    output logic [WIDTH-1:0]  reg_q26,
    output logic [WIDTH-1:0]  reg_q27,
    output logic [WIDTH-1:0]  reg_q28,
    output logic [WIDTH-1:0]  reg_q29,
    output logic [WIDTH-1:0]  reg_q30,
    output logic [WIDTH-1:0]  reg_q31
);

    logic              pend_valid_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [WIDTH-1:0]  pend_data_r;
    logic              commit_s;
    logic              accept_s;
    logic              ready_s;
    logic              zero_hit_s;
    logic [NREG-1:0]   onehot_s;
    logic [NREG-1:1]   load_s;
    logic [WIDTH-1:0]  regs_r [1:NREG-1];

    assign ready_s  = !pend_valid_r || !freeze;
    assign commit_s = pend_valid_r && !freeze;
    assign accept_s = wb_valid && ready_s;

    dec5to32 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr   (pend_addr_r),
        .en     (pend_valid_r),
        .onehot (onehot_s)
    );

    // A hit on register zero suppresses every load, so a faulty decode cannot leak it.
    assign zero_hit_s = onehot_s[REG_ZERO];

    // per-register load enables from the decoded stage address
    always_comb begin
        load_s = '0;
        for (int i = 1; i < NREG; i++) begin
            load_s[i] = onehot_s[i] && commit_s && !zero_hit_s;
        end
    end

    // write-back stage: accept reloads it, a commit without accept empties it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= '0;
            pend_data_r  <= '0;
        end else if (accept_s) begin
            pend_valid_r <= 1'b1;
            pend_addr_r  <= wb_addr;
            pend_data_r  <= wb_data;
        end else if (commit_s) begin
            pend_valid_r <= 1'b0;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // register storage for registers 1..31
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (load_s[i]) begin
                    regs_r[i] <= pend_data_r;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    assign wb_ready   = ready_s;
    assign pend_valid = pend_valid_r;
    assign pend_addr  = pend_addr_r;
    assign pend_data  = pend_data_r;

    assign reg_q0  = {WIDTH{1'b0}};
    assign reg_q1  = regs_r[1];
    assign reg_q2  = regs_r[2];
    assign reg_q3  = regs_r[3];
    assign reg_q4  = regs_r[4];
    assign reg_q5  = regs_r[5];
    assign reg_q6  = regs_r[6];
    assign reg_q7  = regs_r[7];
    assign reg_q8  = regs_r[8];
    assign reg_q9  = regs_r[9];
    assign reg_q10 = regs_r[10];
    assign reg_q11 = regs_r[11];
    assign reg_q12 = regs_r[12];
    assign reg_q13 = regs_r[13];
    assign reg_q14 = regs_r[14];
    assign reg_q15 = regs_r[15];
    assign reg_q16 = regs_r[16];
    assign reg_q17 = regs_r[17];
    assign reg_q18 = regs_r[18];
    assign reg_q19 = regs_r[19];
    assign reg_q20 = regs_r[20];
    assign reg_q21 = regs_r[21];
    assign reg_q22 = regs_r[22];
    assign reg_q23 = regs_r[23];
    assign reg_q24 = regs_r[24];
    assign reg_q25 = regs_r[25];
    assign reg_q26 = regs_r[26];
    assign reg_q27 = regs_r[27];
    assign reg_q28 = regs_r[28];
    assign reg_q29 = regs_r[29];
    assign reg_q30 = regs_r[30];
    assign reg_q31 = regs_r[31];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Bench for regfile_write_bank: directed scenarios then random traffic,
// compared against a queue-based model of the write-back stage and register array.
module tb_regfile_write_bank;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        freeze;
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    logic [31:0] q [32];

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];
    wr_t         m_pend [$];
    wr_t         m_last;

    always #5 clk = ~clk;

    regfile_write_bank dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .freeze(freeze),
        .pend_valid(pend_valid), .pend_addr(pend_addr), .pend_data(pend_data),
        .reg_q0(q[0]),   .reg_q1(q[1]),   .reg_q2(q[2]),   .reg_q3(q[3]),
        .reg_q4(q[4]),   .reg_q5(q[5]),   .reg_q6(q[6]),   .reg_q7(q[7]),
        .reg_q8(q[8]),   .reg_q9(q[9]),   .reg_q10(q[10]), .reg_q11(q[11]),
        .reg_q12(q[12]), .reg_q13(q[13]), .reg_q14(q[14]), .reg_q15(q[15]),
        .reg_q16(q[16]), .reg_q17(q[17]), .reg_q18(q[18]), .reg_q19(q[19]),
        .reg_q20(q[20]), .reg_q21(q[21]), .reg_q22(q[22]), .reg_q23(q[23]),
        .reg_q24(q[24]), .reg_q25(q[25]), .reg_q26(q[26]), .reg_q27(q[27]),
        .reg_q28(q[28]), .reg_q29(q[29]), .reg_q30(q[30]), .reg_q31(q[31])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend.delete();
        m_last = '0;
    endtask

    task automatic check_state();
        chk("pend_valid", {31'd0, pend_valid}, {31'd0, m_pend.size() != 0});
        chk("pend_addr", {27'd0, pend_addr}, {27'd0, m_last.addr});
        chk("pend_data", pend_data, m_last.data);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("reg_q%0d", i), q[i], m_regs[i]);
        end
    endtask

    // One clock: apply inputs just after an edge, check ready, clock, update model, check state.
    task automatic cycle(input logic r, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic f);
        logic rdy;
        logic com;
        wr_t  w;
        rst_n = r; wb_valid = v; wb_addr = a; wb_data = d; freeze = f;
        rdy = (m_pend.size() == 0) || !f;
        com = (m_pend.size() != 0) && !f;
        #1;
        chk("wb_ready", {31'd0, wb_ready}, {31'd0, rdy});
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (com) begin
                w = m_pend.pop_front();
                if (w.addr != 5'd0) m_regs[w.addr] = w.data;
            end
            if (v && rdy) begin
                m_pend.push_back('{a, d});
                m_last = '{a, d};
            end
        end
        #1;
        check_state();
    endtask

    task automatic idle(input logic f);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, f);
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; freeze = 1'b0;
        model_reset();

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, wb_ready}, 32'd1);
        idle(1'b0);

        // 2. single write
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("t2_pend_valid", {31'd0, pend_valid}, 32'd1);
        chk("t2_pend_addr", {27'd0, pend_addr}, 32'd5);
        idle(1'b0);
        chk("t2_reg5", q[5], 32'hDEADBEEF);

        // 3. register zero
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        chk("t3_staged", {31'd0, pend_valid}, 32'd1);
        idle(1'b0);
        chk("t3_reg0", q[0], 32'd0);

        // 4. freeze hold
        cycle(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 5'd8, 32'hBADBAD00, 1'b1);
            chk("t4_ready_low", {31'd0, wb_ready}, 32'd0);
            chk("t4_reg7_held", q[7], 32'd0);
        end
        idle(1'b0);
        chk("t4_reg7", q[7], 32'h12345678);

        // freeze with an empty stage still accepts, then waits
        idle(1'b1);
        cycle(1'b1, 1'b1, 5'd11, 32'h0BADF00D, 1'b1);
        idle(1'b1);
        chk("frz_empty_reg11", q[11], 32'd0);
        idle(1'b0);
        chk("frz_empty_reg11_commit", q[11], 32'h0BADF00D);

        // 5. streaming, last write wins
        cycle(1'b1, 1'b1, 5'd3, 32'h1, 1'b0);
        cycle(1'b1, 1'b1, 5'd4, 32'h2, 1'b0);
        chk("t5_reg3_first", q[3], 32'h1);
        cycle(1'b1, 1'b1, 5'd3, 32'h3, 1'b0);
        idle(1'b0);
        chk("t5_reg3", q[3], 32'h3);
        chk("t5_reg4", q[4], 32'h2);

        // 6. reset mid-operation
        cycle(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("t6_reg9", q[9], 32'd0);
        chk("t6_pend", {31'd0, pend_valid}, 32'd0);
        idle(1'b0);
        chk("t6_reg9_never", q[9], 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(99) < 2) ? 1'b0 : 1'b1,
                  1'($urandom_range(99) < 70),
                  5'($urandom_range(31)),
                  32'($urandom),
                  1'($urandom_range(99) < 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
Write side of the 32x32 MIPS register file; storage plus write-back port.
- Accepts write-back requests through a valid/ready handshake and stages each accepted request for one cycle.
- Decodes the 5-bit destination into a one-hot enable and commits the data into the addressed register.
- Presents all 32 registers in parallel to the 32-to-1 read-port multiplexers, and exposes the staged write for hazard and forwarding logic.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 5, register address width; register count NREG = 2**ADDR_W = 32

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
wb_valid  input  1  write-back request present
wb_ready  output  1  block can accept a request this cycle
wb_addr  input  ADDR_W  destination register number
wb_data  input  WIDTH  value to write
freeze  input  1  hazard-unit stall; blocks commit of the staged write
pend_valid  output  1  staged write is waiting to commit
pend_addr  output  ADDR_W  destination of the staged write
pend_data  output  WIDTH  data of the staged write
reg_q0 .. reg_q31  output  WIDTH each  current register contents, one port per register

Behaviour:
- Reset: when rst_n=0 at a clock edge, reg_q1..reg_q31=0, pend_valid=0, pend_addr=0, pend_data=0. wb_ready=1 after reset.
- reg_q0 is hard-wired 0 at all times. No storage exists for register 0.
- Ready rule (combinational): wb_ready = !pend_valid || !freeze.
- Accept: on an edge with wb_valid && wb_ready, pend_addr <= wb_addr, pend_data <= wb_data, and pend_valid <= 1.
- Commit: on an edge with pend_valid && !freeze, reg[pend_addr] <= pend_data, but only if pend_addr != 0.
  - A write to register 0 is accepted and staged normally, then discarded at commit.
- Clear: after a commit, pend_valid <= 0 unless a new accept occurs on the same edge. If a new accept occurs, the stage is reloaded and pend_valid stays 1.
- Latency: a request accepted at edge N appears on reg_qX after edge N+1, provided freeze=0 at edge N+1. Sustained throughput is one write per cycle.
- Freeze with pend_valid=1: the stage holds its contents, no register changes, and wb_ready=0.
- Freeze with pend_valid=0: wb_ready=1 and a request is accepted. It then waits in the stage until freeze falls.
- wb_valid=0: the stage is unchanged by the accept rule; only the commit rule applies.
- Back-to-back writes to the same address: they commit in order, and the last one wins.
- Reset asserted mid-operation overrides everything. The staged write is dropped and all registers clear on that edge.
- Register outputs update only on clock edges. There is no write-to-read bypass inside the block; the forwarding unit uses the pend_* outputs for that.

Decomposition:
- Shared package: NREG, the WIDTH and ADDR_W defaults, and constant REG_ZERO=5'd0.
- One sub-module, dec5to32: a 5-to-32 one-hot decoder with an enable input. This is the mirror of the read-side mux tree.
  - Its output gates the per-register load enables, each AND-ed with commit.
  - Bit 0 is ignored.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 cycles, release -> all reg_q=0, pend_valid=0, wb_ready=1.
2. Single write: write addr=5, data=32'hDEADBEEF at edge N -> pend_valid=1 and pend_addr=5 after edge N; reg_q5=32'hDEADBEEF after edge N+1; all other registers stay 0.
3. Register zero: write addr=0, data=32'hFFFFFFFF -> the request is staged (pend_valid=1), then reg_q0 remains 0 and no other register changes.
4. Freeze hold: stage addr=7, data=32'h12345678, then freeze=1 for 3 cycles -> wb_ready=0, reg_q7=0 throughout the freeze; after freeze falls, reg_q7=32'h12345678 one edge later.
5. Streaming: consecutive writes (3, 32'h1), (4, 32'h2), (3, 32'h3) with wb_valid held high -> one commit per cycle, final reg_q3=32'h3 and reg_q4=32'h2.
6. Reset mid-operation: stage addr=9, data=32'hA5A5A5A5 and assert rst_n=0 on the next edge -> reg_q9=0, pend_valid=0, and the value is never written.
